// File: rtl/data_sram_bridge_pkg.sv
// Shared types and constants for the CPU data-port to handshaked memory-bus bridge.
package data_sram_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  // Default watchdog budget (REQ+WAIT cycles) and the value a timed-out read returns.
  localparam int unsigned          TIMEOUT_DEFAULT  = 64;
  localparam logic [DATA_W-1:0]    ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // All-zero byte strobes mark a load.
  localparam logic [STRB_W-1:0]    WSTRB_READ = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // One latched bus command, held stable for the whole transaction.
  typedef struct packed {
    logic              wr;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

  // A store is any access with at least one byte strobe set.
  function automatic logic is_write(input logic [STRB_W-1:0] wstrb);
    return wstrb != WSTRB_READ;
  endfunction

endpackage

// File: rtl/data_sram_bridge_bus_timeout_ctr.sv
// Watchdog counter: cleared when a transaction starts, counts REQ/WAIT cycles,
// flags expiry on the last allowed cycle and saturates there.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned     CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise advance while enabled until the last cycle.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/data_sram_bridge.sv
// Bridges the CPU MEM-stage data port (single-cycle expectation) onto a
// request/addr-accept/data-return memory bus, stalling the pipeline meanwhile.
module data_sram_bridge
  import data_sram_bridge_pkg::*;
#(
  parameter int unsigned       TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic [STRB_W-1:0] cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);

  state_e            state_q, state_d;
  bus_cmd_t          cmd_q, cmd_d;
  logic              mem_req_q, mem_req_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              bus_err_q, bus_err_d;

  logic              ctr_clear;
  logic              ctr_enable;
  logic              ctr_expired;

  // Watchdog over the REQ+WAIT window.
  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (ctr_clear),
    .enable  (ctr_enable),
    .expired (ctr_expired)
  );

  // Next-state, latch and stall decode; a data return beats a same-cycle expiry.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    mem_req_d   = mem_req_q;
    cpu_rdata_d = cpu_rdata_q;
    bus_err_d   = bus_err_q;
    ctr_clear   = 1'b0;
    ctr_enable  = 1'b0;
    cpu_stall   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cpu_stall = cpu_en;
        if (cpu_en) begin
          cmd_d     = '{wr: is_write(cpu_wen), wstrb: cpu_wen,
                        addr: cpu_addr, wdata: cpu_wdata};
          mem_req_d = 1'b1;
          ctr_clear = 1'b1;
          state_d   = ST_REQ;
        end
      end

      ST_REQ: begin
        cpu_stall  = 1'b1;
        ctr_enable = 1'b1;
        if (mem_addr_ok && mem_data_ok) begin
          if (!cmd_q.wr) cpu_rdata_d = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
        end else if (ctr_expired) begin
          if (!cmd_q.wr) cpu_rdata_d = ERR_DATA;
          bus_err_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_DONE;
        end else if (mem_addr_ok) begin
          mem_req_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cpu_stall  = 1'b1;
        ctr_enable = 1'b1;
        if (mem_data_ok) begin
          if (!cmd_q.wr) cpu_rdata_d = mem_rdata;
          state_d = ST_DONE;
        end else if (ctr_expired) begin
          if (!cmd_q.wr) cpu_rdata_d = ERR_DATA;
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      mem_req_q   <= 1'b0;
      cpu_rdata_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      mem_req_q   <= mem_req_d;
      cpu_rdata_q <= cpu_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = cmd_q.wr;
  assign mem_wstrb = cmd_q.wstrb;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge: each access is described by its bus
// timing, and the expected per-cycle outputs follow from the access schedule.
module tb_data_sram_bridge;

  localparam int          T   = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;
  logic        bus_err;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  logic        e_stall, e_req, e_wr, e_err;
  logic [3:0]  e_wstrb;
  logic [31:0] e_addr, e_wdata, e_rdata;
  int          stall_cnt = 0;
  int          req_rise  = 0;
  logic        req_prev  = 1'b0;

  data_sram_bridge #(.TIMEOUT(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_en      (cpu_en),
    .cpu_wen     (cpu_wen),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_wstrb   (mem_wstrb),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the schedule-derived expectations.
  always @(negedge clk) begin
    if (chk_on) begin
      check("cpu_stall", 32'(cpu_stall), 32'(e_stall));
      check("mem_req",   32'(mem_req),   32'(e_req));
      check("mem_wr",    32'(mem_wr),    32'(e_wr));
      check("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
      check("mem_addr",  mem_addr,       e_addr);
      check("mem_wdata", mem_wdata,      e_wdata);
      check("cpu_rdata", cpu_rdata,      e_rdata);
      check("bus_err",   32'(bus_err),   32'(e_err));
      if (cpu_stall === 1'b1) stall_cnt++;
      if (mem_req === 1'b1 && req_prev !== 1'b1) req_rise++;
    end
    req_prev = mem_req;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cpu_en = 1'b0; cpu_wen = 4'b0000;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      e_stall = 1'b0; e_req = 1'b0;
    end
  endtask

  // ra: REQ cycle carrying addr_ok (0 = never); wd: WAIT cycles until data_ok
  // (0 = together with addr_ok, <0 = never). Data arriving later than T
  // REQ+WAIT cycles means the watchdog ends the access after exactly T cycles.
  task automatic access(input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ra, input int wd,
                        input logic [31:0] rdat);
    int d, b, r;
    bit tmo, rd;
    rd  = (wen == 4'b0000);
    d   = (ra < 1 || wd < 0) ? 1000 : ra + wd;
    tmo = (d > T);
    b   = tmo ? T : d;
    r   = (ra >= 1 && ra <= b) ? ra : b;
    stall_cnt = 0;
    req_rise  = 0;
    for (int c = 0; c <= b + 1; c++) begin
      @(posedge clk); #1;
      cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
      mem_addr_ok = (c == ra) && (c >= 1) && (c <= b);
      mem_data_ok = !tmo && (c == d);
      mem_rdata   = (c == d) ? rdat : 32'hBAD0_0000 + 32'(c);
      if (c == 0) begin
        e_stall = 1'b1; e_req = 1'b0;
      end else if (c <= b) begin
        e_stall = 1'b1; e_req = (c <= r);
        e_addr = addr; e_wdata = wdata; e_wstrb = wen; e_wr = !rd;
      end else begin
        e_stall = 1'b0; e_req = 1'b0;
        if (rd) e_rdata = tmo ? ERR : rdat;
        if (tmo) e_err = 1'b1;
      end
    end
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; cpu_en = 1'b0; cpu_wen = 4'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    e_stall = 1'b0; e_req = 1'b0; e_wr = 1'b0; e_err = 1'b0;
    e_wstrb = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;

    #2;
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_req",   32'(mem_req), 32'h0);
    check("rst_wr",    32'(mem_wr), 32'h0);
    check("rst_wstrb", 32'(mem_wstrb), 32'h0);
    check("rst_addr",  mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_err",   32'(bus_err), 32'h0);
    check("rst_stall_off", 32'(cpu_stall), 32'h0);
    cpu_en = 1'b1; #1;
    check("rst_stall_en", 32'(cpu_stall), 32'h1);
    cpu_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    idle(2);

    // Read answered in REQ with both oks.
    access(4'b0000, 32'h0000_0040, 32'h0, 1, 0, 32'h1234_5678);
    check("t1_stall_cycles", 32'(stall_cnt), 32'd2);
    check("t1_rdata", cpu_rdata, 32'h1234_5678);
    check("t1_wr", 32'(mem_wr), 32'h0);
    check("t1_req_rise", 32'(req_rise), 32'd1);
    idle(1);

    // Halfword write, slow accept and slow completion.
    access(4'b0011, 32'h0000_0100, 32'hA5A5_5A5A, 3, 3, 32'h0);
    check("t2_stall_cycles", 32'(stall_cnt), 32'd7);
    check("t2_wstrb", 32'(mem_wstrb), 32'h3);
    check("t2_addr", mem_addr, 32'h0000_0100);
    check("t2_rdata_kept", cpu_rdata, 32'h1234_5678);
    idle(2);

    // Back-to-back read then write.
    access(4'b0000, 32'h0000_0200, 32'h0, 1, 0, 32'hCAFE_0001);
    check("t3a_req_rise", 32'(req_rise), 32'd1);
    check("t3a_rdata", cpu_rdata, 32'hCAFE_0001);
    access(4'b1111, 32'h0000_0204, 32'h0BAD_F00D, 2, 1, 32'h0);
    check("t3b_req_rise", 32'(req_rise), 32'd1);
    check("t3b_stall_cycles", 32'(stall_cnt), 32'd4);
    check("t3b_rdata_kept", cpu_rdata, 32'hCAFE_0001);
    idle(1);

    // Data return on the watchdog's last cycle completes normally.
    access(4'b0000, 32'h0000_0300, 32'h0, 1, T - 1, 32'h5555_AAAA);
    check("t4_err", 32'(bus_err), 32'h0);
    check("t4_rdata", cpu_rdata, 32'h5555_AAAA);
    check("t4_stall_cycles", 32'(stall_cnt), 32'd9);
    idle(1);

    // Bus silent after accept: abort with error data.
    access(4'b0000, 32'h0000_0400, 32'h0, 1, -1, 32'h0);
    check("t5_err", 32'(bus_err), 32'h1);
    check("t5_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("t5_stall_cycles", 32'(stall_cnt), 32'd9);
    idle(1);

    // Write never accepted: abort leaves load data alone.
    access(4'b0001, 32'h0000_0500, 32'h0000_00EE, 0, -1, 32'h0);
    check("t6_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
    idle(1);

    // Normal read after an error; the error flag is sticky.
    access(4'b0000, 32'h0000_0600, 32'h0, 2, 2, 32'h7777_0001);
    check("t7_err_sticky", 32'(bus_err), 32'h1);
    check("t7_rdata", cpu_rdata, 32'h7777_0001);
    idle(1);

    // Reset during WAIT, then a stray data return.
    chk_on = 1'b0;
    @(posedge clk); #1;
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_0700;
    @(posedge clk); #1; mem_addr_ok = 1'b1;
    @(posedge clk); #1; mem_addr_ok = 1'b0;
    check("t8_wait_addr", mem_addr, 32'h0000_0700);
    check("t8_wait_stall", 32'(cpu_stall), 32'h1);
    #2; rst = 1'b1; #1;
    check("t8_rst_req", 32'(mem_req), 32'h0);
    check("t8_rst_addr", mem_addr, 32'h0);
    check("t8_rst_rdata", cpu_rdata, 32'h0);
    check("t8_rst_err", 32'(bus_err), 32'h0);
    check("t8_rst_wstrb", 32'(mem_wstrb), 32'h0);
    check("t8_rst_stall_en", 32'(cpu_stall), 32'h1);
    cpu_en = 1'b0; #1;
    check("t8_rst_stall_off", 32'(cpu_stall), 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_0000;
    @(posedge clk); #1; mem_data_ok = 1'b0;
    check("t8_stray_rdata", cpu_rdata, 32'h0);
    check("t8_stray_stall", 32'(cpu_stall), 32'h0);
    check("t8_stray_req", 32'(mem_req), 32'h0);
    e_stall = 1'b0; e_req = 1'b0; e_wr = 1'b0; e_err = 1'b0;
    e_wstrb = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    chk_on = 1'b1;
    idle(1);

    access(4'b0000, 32'h0000_0800, 32'h0, 1, 0, 32'h8888_0008);
    check("t9_rdata", cpu_rdata, 32'h8888_0008);
    check("t9_err", 32'(bus_err), 32'h0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_watchdog: time limit reached, got no end expected $finish");
    $fatal(1);
  end

endmodule

// File: doc/data_sram_bridge.md
# data_sram_bridge

Bridges the CPU's data-memory port to a variable-latency, handshaked memory bus. The CPU port expects an answer in the next cycle. The bus instead uses request/address-accept/data-return handshakes. The bridge sits directly downstream of the CPU's MEM stage. It latches each access, runs the bus handshake, and holds the pipeline with a stall output until read data is captured or the write is acknowledged. A timeout watchdog ends any access the bus never answers.

## Interface
- TIMEOUT, 64, cycles allowed in REQ+WAIT before the access is aborted (≥2)
- ERR_DATA, 32'hDEAD_BEEF, value returned on `cpu_rdata` for an aborted read
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- cpu_en  in  1  MEM stage has a valid load/store this cycle
- cpu_wen  in  4  byte write strobes; 4'b0000 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  registered load data; valid in the cycle `cpu_stall` falls
- cpu_stall  out  1  freeze the F/D/E/M pipeline registers
- mem_req  out  1  bus request
- mem_wr  out  1  1 = write
- mem_wstrb  out  4  byte strobes (copy of latched `cpu_wen`)
- mem_addr  out  32  latched address
- mem_wdata  out  32  latched store data
- mem_addr_ok  in  1  bus accepted the request this cycle
- mem_data_ok  in  1  read data valid / write complete this cycle
- mem_rdata  in  32  read data, sampled only when `mem_data_ok`=1
- bus_err  out  1  sticky timeout flag, cleared only by `rst`

## Operation
- States: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - `cpu_en`=1: latch addr/wen/wdata, `mem_wr`=|`cpu_wen`, go to REQ.
  - `mem_data_ok` or `mem_addr_ok` in IDLE is ignored (stale responses after reset).
- **REQ**
  - `mem_req`=1; `mem_addr`, `mem_wr`, `mem_wstrb`, `mem_wdata` held stable.
  - `mem_addr_ok`=1 and `mem_data_ok`=1: capture data, go to DONE.
  - `mem_addr_ok`=1 alone: go to WAIT.
- **WAIT**
  - `mem_req`=0.
  - `mem_data_ok`=1: on a read, `cpu_rdata` <= `mem_rdata`; on a write, `cpu_rdata` is unchanged. Go to DONE.
- **DONE**
  - One cycle; the pipeline advances at the end of it. Always returns to IDLE.
  - A back-to-back access is re-latched from IDLE on the next cycle; there is no DONE→REQ shortcut.
- **cpu_stall** (combinational): 1 in (IDLE && `cpu_en`), REQ, and WAIT; 0 in DONE and in idle IDLE.
- **Watchdog**
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - Reaching TIMEOUT−1 without `mem_data_ok`:
    - `bus_err`<=1 and go to DONE.
    - On a read, `cpu_rdata`<=ERR_DATA.
    - `mem_req` drops that cycle.
  - A `mem_data_ok` in the same cycle as expiry wins: no error is flagged.
- No queuing: at most one outstanding bus transaction.

## Timing
- Reset values: state IDLE, `cpu_rdata`=0, `mem_req`=0, `mem_wr`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0, `bus_err`=0, counter=0.
- `cpu_stall` reset value = `cpu_en` (combinational from IDLE).
- Reset mid-access is asynchronous: `mem_req` falls immediately and the transaction is abandoned.
- Minimum access = 3 cycles: IDLE-latch, REQ with both oks, DONE.
- Stall cycles = 2 + bus latency.
- `cpu_rdata` is registered and keeps its value until the next completed read or abort.

## Structure
- Shared package holds:
  - state encoding (2-bit)
  - TIMEOUT and ERR_DATA defaults
  - the `wstrb==0 → read` rule constant
- One sub-module, `bus_timeout_ctr`:
  - inputs: clk, rst, clear, enable
  - output: expired
  - width = $clog2(TIMEOUT)
- FSM, latches and stall logic stay in the top module.

## Test plan
- Read, bus answers `addr_ok` and `data_ok` together in REQ with `mem_rdata`=32'h1234_5678 → `cpu_stall` high for 2 cycles, DONE shows `cpu_rdata`=32'h1234_5678, `mem_wr`=0.
- Write with `cpu_wen`=4'b0011, addr 0x100, `addr_ok` after 2 cycles, `data_ok` 3 cycles later → `mem_wstrb`=4'b0011 and addr/data held through REQ, stall for 7 cycles, `cpu_rdata` unchanged.
- Back-to-back read then write → two separate REQ phases, DONE between them, exactly one `mem_req` rising edge each.
- TIMEOUT=8, bus silent after `addr_ok` → DONE after 8 REQ+WAIT cycles, `bus_err`=1, `cpu_rdata`=32'hDEAD_BEEF; a later normal read still completes and `bus_err` stays 1.
- `rst` asserted in WAIT, then a stray `mem_data_ok` right after release → all outputs at reset values at once, stray response ignored, `cpu_rdata`=0.
- `mem_data_ok` on the same cycle the watchdog expires → normal completion, `bus_err`=0.
